// File: rtl/gate2_tester.sv
// gate2_tester: sweeps a two-input gate through all four input vectors,
// checks each sampled output against the selected truth table.
module gate2_tester #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       x,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec,
  output logic       sel_err
);

  localparam logic [7:0] LP_LAST = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;

  logic [2:0] r_sel;
  logic [1:0] r_v;
  logic [7:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err;
  logic [1:0] r_fvec;
  logic       r_selerr;

  logic [2:0] w_sel_nx;
  logic [1:0] w_v_nx;
  logic [7:0] w_cnt_nx;
  logic       w_a_nx;
  logic       w_b_nx;
  logic       w_busy_nx;
  logic       w_done_nx;
  logic       w_pass_nx;
  logic [2:0] w_err_nx;
  logic [1:0] w_fvec_nx;
  logic       w_selerr_nx;

  logic       w_legal;
  logic       w_sample;
  logic       w_last;
  logic       w_exp;
  logic       w_miss;
  logic [1:0] w_v_inc;

  assign w_legal  = (gate_sel <= 3'd5);
  assign w_sample = (r_state == S_RUN) && (r_cnt == LP_LAST);
  assign w_last   = (r_v == 2'd3);
  assign w_v_inc  = r_v + 2'd1;
  assign w_miss   = w_sample && (x != w_exp);

  always_comb begin
    w_exp = 1'b0;
    unique case (r_sel)
      3'd0:    w_exp = r_a & r_b;
      3'd1:    w_exp = r_a | r_b;
      3'd2:    w_exp = r_a ^ r_b;
      3'd3:    w_exp = ~(r_a & r_b);
      3'd4:    w_exp = ~(r_a | r_b);
      3'd5:    w_exp = ~(r_a ^ r_b);
      default: w_exp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = w_legal ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_sample && w_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nx    = r_sel;
    w_v_nx      = r_v;
    w_cnt_nx    = r_cnt;
    w_a_nx      = r_a;
    w_b_nx      = r_b;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_pass_nx   = r_pass;
    w_err_nx    = r_err;
    w_fvec_nx   = r_fvec;
    w_selerr_nx = r_selerr;
    unique case (r_state)
      S_IDLE: begin
        w_a_nx = 1'b0;
        w_b_nx = 1'b0;
        if (start) begin
          w_err_nx  = 3'd0;
          w_fvec_nx = 2'd0;
          w_pass_nx = 1'b0;
          if (w_legal) begin
            w_sel_nx    = gate_sel;
            w_v_nx      = 2'd0;
            w_cnt_nx    = 8'd0;
            w_busy_nx   = 1'b1;
            w_selerr_nx = 1'b0;
          end else begin
            w_selerr_nx = 1'b1;
            w_done_nx   = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_cnt_nx = r_cnt + 8'd1;
        if (w_sample) begin
          w_cnt_nx = 8'd0;
          if (w_miss) begin
            w_err_nx = r_err + 3'd1;
            if (r_err == 3'd0) begin
              w_fvec_nx = r_v;
            end
          end
          if (!w_last) begin
            w_v_nx = w_v_inc;
            w_a_nx = w_v_inc[1];
            w_b_nx = w_v_inc[0];
          end else begin
            w_busy_nx = 1'b0;
            w_done_nx = 1'b1;
            w_pass_nx = (r_err == 3'd0) && !w_miss;
          end
        end
      end
      S_DONE: begin
        w_a_nx = 1'b0;
        w_b_nx = 1'b0;
      end
      default: begin
        w_a_nx    = 1'b0;
        w_b_nx    = 1'b0;
        w_busy_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= 3'd0;
      r_v      <= 2'd0;
      r_cnt    <= 8'd0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= 3'd0;
      r_fvec   <= 2'd0;
      r_selerr <= 1'b0;
    end else begin
      r_sel    <= w_sel_nx;
      r_v      <= w_v_nx;
      r_cnt    <= w_cnt_nx;
      r_a      <= w_a_nx;
      r_b      <= w_b_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_pass   <= w_pass_nx;
      r_err    <= w_err_nx;
      r_fvec   <= w_fvec_nx;
      r_selerr <= w_selerr_nx;
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_vec = r_fvec;
  assign sel_err  = r_selerr;

endmodule
